// File: rtl/redmule_x_buffer_sched.sv
// X operand buffer sequencer: accepts streamer beats, drives load/shift strobes and
// leftover fields, and paces cfg_n_tiles tiles per job through the PE array.
module redmule_x_buffer_sched #(
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned ARRAY_WIDTH  = 12,
  parameter int unsigned PIPE_REGS    = 3,
  parameter int unsigned CntW         = 16
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             clear_i,
  input  logic                                             start_i,
  input  logic [CntW-1:0]                                  cfg_n_tiles_i,
  input  logic [$clog2(ARRAY_WIDTH):0]                     cfg_rows_lftovr_i,
  input  logic [$clog2(ARRAY_HEIGHT*(PIPE_REGS+1)):0]      cfg_cols_lftovr_i,
  input  logic [$clog2(PIPE_REGS+1):0]                     cfg_slots_i,
  input  logic                                             x_valid_i,
  output logic                                             x_ready_o,
  input  logic                                             buf_full_i,
  input  logic                                             buf_empty_i,
  input  logic                                             advance_i,
  output logic                                             load_o,
  output logic                                             blck_shift_o,
  output logic                                             d_shift_o,
  output logic                                             h_shift_o,
  output logic [$clog2(ARRAY_WIDTH):0]                     rows_lftovr_o,
  output logic [$clog2(ARRAY_HEIGHT*(PIPE_REGS+1)):0]      cols_lftovr_o,
  output logic [$clog2(PIPE_REGS+1):0]                     slots_o,
  output logic                                             clear_o,
  output logic                                             busy_o,
  output logic                                             done_o
);

  localparam int unsigned HW = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(ARRAY_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, PRIME, COMPUTE, TILE_END, DONE
  } state_t;

  state_t          state;
  logic [CntW-1:0] tile_cnt;
  logic [CntW-1:0] tile_last;
  logic [HW-1:0]   h_cnt;

  // Strobes are Mealy; reset and clear suppress every strobe in their cycle.
  always_comb begin
    x_ready_o    = 1'b0;
    load_o       = 1'b0;
    blck_shift_o = 1'b0;
    d_shift_o    = 1'b0;
    h_shift_o    = 1'b0;
    clear_o      = 1'b0;
    if (!rst_i) begin
      if (clear_i) begin
        clear_o = 1'b1;
      end else begin
        case (state)
          IDLE:    clear_o = start_i;
          LOAD: begin
            x_ready_o = ~buf_full_i;
            load_o    = x_valid_i & ~buf_full_i;
          end
          PRIME:   blck_shift_o = 1'b1;
          COMPUTE: begin
            if (advance_i) begin
              if (h_cnt != H_LAST) h_shift_o = 1'b1;
              else if (!buf_empty_i) d_shift_o = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE) & ~clear_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      tile_cnt      <= '0;
      tile_last     <= '0;
      h_cnt         <= '0;
      rows_lftovr_o <= '0;
      cols_lftovr_o <= '0;
      slots_o       <= '0;
    end else if (clear_i) begin
      state    <= IDLE;
      tile_cnt <= '0;
      h_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            rows_lftovr_o <= cfg_rows_lftovr_i;
            cols_lftovr_o <= cfg_cols_lftovr_i;
            slots_o       <= cfg_slots_i;
            // A zero tile count is run as a single tile.
            tile_last     <= (cfg_n_tiles_i == '0) ? '0 : cfg_n_tiles_i - CntW'(1);
            tile_cnt      <= '0;
            h_cnt         <= '0;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (buf_full_i) state <= PRIME;
        end
        PRIME: begin
          h_cnt <= '0;
          state <= COMPUTE;
        end
        COMPUTE: begin
          if (advance_i) begin
            if (h_cnt != H_LAST) begin
              h_cnt <= h_cnt + HW'(1);
            end else begin
              h_cnt <= '0;
              if (buf_empty_i) state <= TILE_END;
            end
          end
        end
        TILE_END: begin
          if (tile_cnt == tile_last) begin
            tile_cnt <= '0;
            state    <= DONE;
          end else begin
            tile_cnt <= tile_cnt + CntW'(1);
            state    <= LOAD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redmule_x_buffer_sched.sv
// Directed bench for redmule_x_buffer_sched with a small behavioural X buffer model
// that raises full after ARRAY_WIDTH loads and empty after two depth shifts.
module tb_redmule_x_buffer_sched;

  localparam int H   = 4;
  localparam int W   = 12;
  localparam int PR  = 3;
  localparam int CW  = 16;
  localparam int RW  = $clog2(W) + 1;
  localparam int CLW = $clog2(H * (PR + 1)) + 1;
  localparam int SW  = $clog2(PR + 1) + 1;
  localparam int NDS = 2;

  logic          clk_i = 1'b0;
  logic          rst_i, clear_i, start_i;
  logic [CW-1:0] cfg_n_tiles_i;
  logic [RW-1:0] cfg_rows_lftovr_i;
  logic [CLW-1:0] cfg_cols_lftovr_i;
  logic [SW-1:0] cfg_slots_i;
  logic          x_valid_i, x_ready_o, buf_full_i, buf_empty_i, advance_i;
  logic          load_o, blck_shift_o, d_shift_o, h_shift_o;
  logic [RW-1:0] rows_lftovr_o;
  logic [CLW-1:0] cols_lftovr_o;
  logic [SW-1:0] slots_o;
  logic          clear_o, busy_o, done_o;

  redmule_x_buffer_sched #(
    .ARRAY_HEIGHT(H), .ARRAY_WIDTH(W), .PIPE_REGS(PR), .CntW(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .cfg_n_tiles_i(cfg_n_tiles_i), .cfg_rows_lftovr_i(cfg_rows_lftovr_i),
    .cfg_cols_lftovr_i(cfg_cols_lftovr_i), .cfg_slots_i(cfg_slots_i),
    .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .buf_full_i(buf_full_i),
    .buf_empty_i(buf_empty_i), .advance_i(advance_i), .load_o(load_o),
    .blck_shift_o(blck_shift_o), .d_shift_o(d_shift_o), .h_shift_o(h_shift_o),
    .rows_lftovr_o(rows_lftovr_o), .cols_lftovr_o(cols_lftovr_o), .slots_o(slots_o),
    .clear_o(clear_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  logic s_load, s_blck, s_d, s_h, s_clr, s_done, s_busy, s_rdy;
  int c_load, c_blck, c_d, c_h, c_clr, c_done;
  int n_excl, n_badload, n_badrdy;
  int rows, d_cnt;
  bit primed;
  int steps_to_done;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    c_load = 0; c_blck = 0; c_d = 0; c_h = 0; c_clr = 0; c_done = 0;
    n_excl = 0; n_badload = 0; n_badrdy = 0;
  endtask

  task automatic drive_model();
    buf_full_i  = (rows == W);
    buf_empty_i = primed && (d_cnt == NDS);
  endtask

  // Entered at posedge+1: sample mid-cycle, then advance one clock and update the buffer model.
  task automatic step();
    #3;
    s_load = load_o; s_blck = blck_shift_o; s_d = d_shift_o; s_h = h_shift_o;
    s_clr = clear_o; s_done = done_o; s_busy = busy_o; s_rdy = x_ready_o;
    c_load += int'(s_load); c_blck += int'(s_blck); c_d += int'(s_d);
    c_h += int'(s_h); c_clr += int'(s_clr); c_done += int'(s_done);
    if (int'(s_load) + int'(s_blck) + int'(s_d) + int'(s_h) > 1) n_excl++;
    if (s_load && !x_valid_i) n_badload++;
    if (s_rdy && buf_full_i) n_badrdy++;
    @(posedge clk_i);
    #1;
    if (rst_i || s_clr) begin
      rows = 0; d_cnt = 0; primed = 0;
    end else begin
      if (s_load) rows++;
      if (s_blck) begin rows = 0; d_cnt = 0; primed = 1; end
      if (s_d) d_cnt++;
    end
    drive_model();
  endtask

  task automatic run_job(input logic [CW-1:0] n, input bit toggle_valid, input bit hold_start,
                         input int budget);
    clr_counts();
    steps_to_done = -1;
    cfg_n_tiles_i = n;
    start_i = 1'b1; x_valid_i = 1'b1; advance_i = 1'b1;
    step();
    if (hold_start) begin
      cfg_n_tiles_i = 16'd7; cfg_rows_lftovr_i = 5'd1; cfg_cols_lftovr_i = 5'd1; cfg_slots_i = 3'd1;
    end else begin
      start_i = 1'b0;
    end
    for (int k = 1; k < budget; k++) begin
      x_valid_i = toggle_valid ? ((k % 2) == 0) : 1'b1;
      step();
      if (s_done) begin
        steps_to_done = k;
        break;
      end
    end
    start_i = 1'b0;
    if (steps_to_done < 0) check_val("job_timeout", 0, 1);
    x_valid_i = 1'b0;
    step();
    check_val("busy_after_done", s_busy, 0);
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; x_valid_i = 1'b0; advance_i = 1'b0;
    cfg_n_tiles_i = '0; cfg_rows_lftovr_i = '0; cfg_cols_lftovr_i = '0; cfg_slots_i = '0;
    rows = 0; d_cnt = 0; primed = 0;
    drive_model();
    clr_counts();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step();
    check_val("rst_busy", s_busy, 0);
    check_val("rst_done", s_done, 0);
    check_val("rst_clear", s_clr, 0);
    check_val("rst_ready", s_rdy, 0);
    check_val("rst_strobes", int'(s_load) + int'(s_blck) + int'(s_d) + int'(s_h), 0);
    check_val("rst_rows", rows_lftovr_o, 0);
    check_val("rst_cols", cols_lftovr_o, 0);
    check_val("rst_slots", slots_o, 0);

    // Single tile, valid always high: 12 loads, 1 prime, hhhd hhhd hhh, done at step 28.
    cfg_rows_lftovr_i = 5'd7; cfg_cols_lftovr_i = 5'd9; cfg_slots_i = 3'd3;
    run_job(16'd1, 1'b0, 1'b0, 200);
    check_val("a_loads", c_load, 12);
    check_val("a_prime", c_blck, 1);
    check_val("a_hshift", c_h, 9);
    check_val("a_dshift", c_d, 2);
    check_val("a_done", c_done, 1);
    check_val("a_clear", c_clr, 1);
    check_val("a_latency", steps_to_done, 28);
    check_val("a_excl", n_excl, 0);
    check_val("a_rows", rows_lftovr_o, 7);
    check_val("a_cols", cols_lftovr_o, 9);
    check_val("a_slots", slots_o, 3);

    // Valid toggling: loads only on valid cycles, ready low while full.
    run_job(16'd1, 1'b1, 1'b0, 200);
    check_val("b_loads", c_load, 12);
    check_val("b_badload", n_badload, 0);
    check_val("b_badrdy", n_badrdy, 0);
    check_val("b_done", c_done, 1);

    // Three tiles with start_i held and cfg changed mid-job: latched values must win.
    cfg_rows_lftovr_i = 5'd5; cfg_cols_lftovr_i = 5'd11; cfg_slots_i = 3'd2;
    run_job(16'd3, 1'b0, 1'b1, 400);
    check_val("c_prime", c_blck, 3);
    check_val("c_loads", c_load, 36);
    check_val("c_done", c_done, 1);
    check_val("c_clear", c_clr, 1);
    check_val("c_excl", n_excl, 0);
    check_val("c_rows", rows_lftovr_o, 5);
    check_val("c_cols", cols_lftovr_o, 11);
    check_val("c_slots", slots_o, 2);

    // Clear during LOAD with a simultaneous valid beat.
    cfg_n_tiles_i = 16'd1; start_i = 1'b1; x_valid_i = 1'b1; advance_i = 1'b0;
    step();
    start_i = 1'b0;
    repeat (3) step();
    clear_i = 1'b1;
    step();
    check_val("clr_pulse", s_clr, 1);
    check_val("clr_load", s_load, 0);
    check_val("clr_ready", s_rdy, 0);
    clear_i = 1'b0;
    step();
    check_val("clr_idle", s_busy, 0);
    check_val("clr_noload", s_load, 0);

    // Reset in COMPUTE with h_cnt = 2.
    clr_counts();
    start_i = 1'b1; x_valid_i = 1'b1; advance_i = 1'b0;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (s_blck) break;
    end
    check_val("r_primed", c_blck, 1);
    advance_i = 1'b1;
    step();
    step();
    check_val("r_hsteps", c_h, 2);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    check_val("r_busy", s_busy, 0);
    check_val("r_hshift", s_h, 0);
    check_val("r_rows", rows_lftovr_o, 0);
    check_val("r_slots", slots_o, 0);

    // Zero tile count runs as one tile.
    cfg_rows_lftovr_i = 5'd3; cfg_cols_lftovr_i = 5'd4; cfg_slots_i = 3'd1;
    run_job(16'd0, 1'b0, 1'b0, 200);
    check_val("z_prime", c_blck, 1);
    check_val("z_done", c_done, 1);
    check_val("z_hshift", c_h, 9);
    check_val("z_latency", steps_to_done, 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
